// File: rtl/pipeline_slice_chain.sv
// Cascaded valid/ready register slices with skid buffering, synchronous flush and occupancy count.
// MODE 0 registers both directions, MODE 1 registers the forward path only, MODE 2 is pure wiring.
module pipeline_slice_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter int MODE       = 0,
  parameter int OCC_W      = $clog2(2*STAGES+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] u_data,
  input  logic                  u_valid,
  output logic                  u_ready,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [OCC_W-1:0]      occupancy
);

  if (STAGES < 1 || STAGES > 8 || MODE < 0 || MODE > 2) begin : g_cfg_check
    $error("pipeline_slice_chain: unsupported STAGES=%0d MODE=%0d", STAGES, MODE);
  end

  if (MODE == 2) begin : g_bypass
    logic unused_ok;

    assign d_data    = u_data;
    assign d_valid   = u_valid;
    assign u_ready   = d_ready;
    assign occupancy = '0;
    assign unused_ok = &{1'b0, clk, rst_n, flush};
  end else begin : g_reg
    logic [STAGES-1:0]     m_valid;
    logic [DATA_WIDTH-1:0] m_data [STAGES];
    logic [STAGES-1:0]     v_chain;
    logic [DATA_WIDTH-1:0] d_chain [STAGES];
    logic [OCC_W-1:0]      occ_q;
    logic                  in_fire;
    logic                  out_fire;

    // Slice i is fed by the upstream port (i == 0) or by the main register of slice i-1.
    always_comb begin
      v_chain[0] = u_valid;
      d_chain[0] = u_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        v_chain[i] = m_valid[i-1];
        d_chain[i] = m_data[i-1];
      end
    end

    assign d_valid  = m_valid[STAGES-1] & ~flush;
    assign d_data   = m_data[STAGES-1];
    assign in_fire  = u_valid & u_ready;
    assign out_fire = d_valid & d_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occ_q <= '0;
      end else if (flush) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
      end
    end

    assign occupancy = occ_q;

    if (MODE == 0) begin : g_full
      logic [STAGES-1:0]     s_valid;
      logic [STAGES-1:0]     rdy;
      logic [STAGES-1:0]     nr;
      logic [DATA_WIDTH-1:0] s_data [STAGES];

      always_comb begin
        nr = '0;
        for (int unsigned i = 0; i + 1 < STAGES; i++) begin
          nr[i] = rdy[i+1];
        end
        nr[STAGES-1] = d_ready;
      end

      assign u_ready = rdy[0] & ~flush;

      // rdy tracks !s_valid one edge late so the ready path stays a flop; it reads 0 after reset/flush.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_valid <= '0;
          s_valid <= '0;
          rdy     <= '0;
          for (int unsigned i = 0; i < STAGES; i++) begin
            m_data[i] <= '0;
            s_data[i] <= '0;
          end
        end else if (flush) begin
          m_valid <= '0;
          s_valid <= '0;
          rdy     <= '0;
        end else begin
          for (int unsigned i = 0; i < STAGES; i++) begin
            if (!m_valid[i] || nr[i]) begin
              if (s_valid[i]) begin
                m_valid[i] <= 1'b1;
                m_data[i]  <= s_data[i];
                s_valid[i] <= 1'b0;
              end else begin
                m_valid[i] <= v_chain[i] & rdy[i];
                if (v_chain[i] && rdy[i]) begin
                  m_data[i] <= d_chain[i];
                end
              end
              rdy[i] <= 1'b1;
            end else if (v_chain[i] && rdy[i]) begin
              s_valid[i] <= 1'b1;
              s_data[i]  <= d_chain[i];
              rdy[i]     <= 1'b0;
            end else begin
              rdy[i] <= ~s_valid[i];
            end
          end
        end
      end
    end else begin : g_fwd
      logic [STAGES-1:0] slot_rdy;

      // Ready ripples from the downstream end: a slice can accept if it or anything after it has a bubble.
      always_comb begin
        logic run;
        run      = d_ready;
        slot_rdy = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
          run                    = ~m_valid[STAGES-1-k] | run;
          slot_rdy[STAGES-1-k]   = run;
        end
      end

      assign u_ready = slot_rdy[0] & ~flush;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_valid <= '0;
          for (int unsigned i = 0; i < STAGES; i++) begin
            m_data[i] <= '0;
          end
        end else if (flush) begin
          m_valid <= '0;
        end else begin
          for (int unsigned i = 0; i < STAGES; i++) begin
            if (slot_rdy[i]) begin
              m_valid[i] <= v_chain[i];
              if (v_chain[i]) begin
                m_data[i] <= d_chain[i];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_slice_chain.sv
// Bench for pipeline_slice_chain: directed and random streams on three configurations,
// checked against a queue model of accepted beats.
module tb_pipeline_slice_chain;

  logic        clk;
  logic        rst_n;
  logic        flush_a   [3];
  logic        u_valid_a [3];
  logic [31:0] u_data_a  [3];
  logic        u_ready_a [3];
  logic        d_valid_a [3];
  logic [31:0] d_data_a  [3];
  logic        d_ready_a [3];
  logic [3:0]  occ_a     [3];
  logic [2:0]  occ0;
  logic [2:0]  occ1;
  logic [3:0]  occ2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_in;
  int n_out;
  int cur_k;
  int cur_mode;
  int cur_stages;
  int cur_cap;

  logic        s_ur;
  logic        s_dv;
  logic        s_out;
  logic [31:0] s_dd;
  int          s_oc;
  int          s_cyc;

  logic [31:0] model_q [$];
  int          acc_q   [$];

  pipeline_slice_chain #(.DATA_WIDTH(32), .STAGES(2), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush_a[0]),
    .u_data(u_data_a[0]), .u_valid(u_valid_a[0]), .u_ready(u_ready_a[0]),
    .d_data(d_data_a[0]), .d_valid(d_valid_a[0]), .d_ready(d_ready_a[0]),
    .occupancy(occ0)
  );

  pipeline_slice_chain #(.DATA_WIDTH(32), .STAGES(3), .MODE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_a[1]),
    .u_data(u_data_a[1]), .u_valid(u_valid_a[1]), .u_ready(u_ready_a[1]),
    .d_data(d_data_a[1]), .d_valid(d_valid_a[1]), .d_ready(d_ready_a[1]),
    .occupancy(occ1)
  );

  pipeline_slice_chain #(.DATA_WIDTH(32), .STAGES(4), .MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush_a[2]),
    .u_data(u_data_a[2]), .u_valid(u_valid_a[2]), .u_ready(u_ready_a[2]),
    .d_data(d_data_a[2]), .d_valid(d_valid_a[2]), .d_ready(d_ready_a[2]),
    .occupancy(occ2)
  );

  assign occ_a[0] = {1'b0, occ0};
  assign occ_a[1] = {1'b0, occ1};
  assign occ_a[2] = occ2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sel(input int k, input int mode, input int stages);
    cur_k      = k;
    cur_mode   = mode;
    cur_stages = stages;
    cur_cap    = (mode == 0) ? 2 * stages : stages;
    n_in       = 0;
    n_out      = 0;
    model_q.delete();
    acc_q.delete();
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later, update the model.
  task automatic step(input logic uv, input logic [31:0] ud, input logic dr, input logic fl);
    logic ur2;
    @(negedge clk);
    u_valid_a[cur_k] = uv;
    u_data_a[cur_k]  = ud;
    d_ready_a[cur_k] = dr;
    flush_a[cur_k]   = fl;
    #1;
    s_ur  = u_ready_a[cur_k];
    s_dv  = d_valid_a[cur_k];
    s_dd  = d_data_a[cur_k];
    s_oc  = int'(occ_a[cur_k]);
    s_cyc = cyc;
    s_out = 1'b0;
    chk("occupancy", s_oc, model_q.size());
    if (fl) begin
      chk("flush_u_ready", int'(s_ur), 0);
      chk("flush_d_valid", int'(s_dv), 0);
      model_q.delete();
      acc_q.delete();
    end else begin
      if (cur_mode == 0) begin
        d_ready_a[cur_k] = ~dr;
        #1;
        ur2 = u_ready_a[cur_k];
        chk("u_ready_registered", int'(ur2), int'(s_ur));
        d_ready_a[cur_k] = dr;
        #1;
        if (model_q.size() == cur_cap) chk("full_u_ready", int'(s_ur), 0);
      end else begin
        chk("mode1_u_ready", int'(s_ur), int'((model_q.size() < cur_cap) || dr));
      end
      if (s_dv && dr) begin
        chk("out_nonempty", int'(model_q.size() > 0), 1);
        if (model_q.size() > 0) begin
          chk("d_data_order", int'(s_dd), int'(model_q[0]));
          chk("min_latency", int'((s_cyc - acc_q[0]) >= cur_stages), 1);
          void'(model_q.pop_front());
          void'(acc_q.pop_front());
          s_out = 1'b1;
          n_out++;
        end
      end
      if (uv && s_ur) begin
        model_q.push_back(ud);
        acc_q.push_back(s_cyc);
        n_in++;
      end
      chk("capacity", int'(model_q.size() <= cur_cap), 1);
    end
    cyc++;
  endtask

  int          first_acc;
  int          first_dv;
  logic        seen;
  logic [31:0] first_val;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush_a[i]   = 1'b0;
      u_valid_a[i] = 1'b0;
      u_data_a[i]  = '0;
      d_ready_a[i] = 1'b0;
    end

    // Reset state and release timing
    sel(0, 0, 2);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_d_valid", int'(d_valid_a[0]), 0);
    chk("rst_occupancy", int'(occ_a[0]), 0);
    chk("rst_u_ready", int'(u_ready_a[0]), 0);
    chk("rst_d_data", int'(d_data_a[0]), 0);
    chk("rst_m1_d_valid", int'(d_valid_a[2]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("u_ready_before_first_edge", int'(u_ready_a[0]), 0);

    // Back-to-back stream with d_ready held high
    first_acc = -1;
    first_dv  = -1;
    for (int c = 0; c < 20; c++) begin
      step(c < 16, 32'(c + 1), 1'b1, 1'b0);
      if (c < 16) chk("b2b_u_ready", int'(s_ur), 1);
      if (s_ur && c < 16 && first_acc < 0) first_acc = s_cyc;
      if (s_dv && first_dv < 0) first_dv = s_cyc;
      if (c >= 2 && c <= 16) chk("b2b_steady_occ", s_oc, 2);
      if (c >= 2 && c < 18) chk("b2b_d_valid", int'(s_dv), 1);
    end
    chk("b2b_first_latency", first_dv - first_acc, 2);
    chk("b2b_delivered", n_out, 16);

    // Full backpressure: exactly 2*STAGES accepted, first beat held
    sel(0, 0, 2);
    for (int c = 0; c < 10; c++) step(1'b1, 32'h100 + 32'(c), 1'b0, 1'b0);
    chk("bp_accepted", n_in, 4);
    chk("bp_u_ready", int'(s_ur), 0);
    chk("bp_occupancy", s_oc, 4);
    chk("bp_d_valid", int'(s_dv), 1);
    chk("bp_hold_first", int'(s_dd), 'h100);
    for (int c = 0; c < 12; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_delivered", n_out, 4);

    // Flush with three beats held and upstream still offering
    sel(0, 0, 2);
    for (int c = 0; c < 3; c++) step(1'b1, 32'h200 + 32'(c), 1'b0, 1'b0);
    step(1'b1, 32'h203, 1'b1, 1'b1);
    chk("flush_cycle_occ", s_oc, 3);
    step(1'b1, 32'h204, 1'b1, 1'b0);
    chk("post_flush_occ", s_oc, 0);
    chk("post_flush_d_valid", int'(s_dv), 0);
    chk("post_flush_u_ready", int'(s_ur), 0);
    step(1'b1, 32'h205, 1'b1, 1'b0);
    chk("flush_recover_u_ready", int'(s_ur), 1);
    seen      = 1'b0;
    first_val = '0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (s_out && !seen) begin
        seen      = 1'b1;
        first_val = s_dd;
      end
    end
    chk("first_after_flush", int'(first_val), 'h205);
    chk("flush_delivered", n_out, 1);

    // Asynchronous reset mid-stream
    sel(0, 0, 2);
    for (int c = 0; c < 6; c++) step(1'b1, 32'h280 + 32'(c), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_occ", int'(occ_a[0]), 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_d_valid", int'(d_valid_a[0]), 0);
    chk("async_rst_occ", int'(occ_a[0]), 0);
    chk("async_rst_u_ready", int'(u_ready_a[0]), 0);
    sel(0, 0, 2);
    u_valid_a[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_u_ready", int'(u_ready_a[0]), 0);
    step(1'b1, 32'h300, 1'b1, 1'b0);
    chk("restart_u_ready", int'(s_ur), 1);
    for (int c = 1; c < 8; c++) step(1'b1, 32'h300 + 32'(c), 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("restart_delivered", n_out, 8);

    // Random traffic on the three-stage full slice
    sel(1, 0, 3);
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int c = 0; c < 40 && model_q.size() > 0; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("rand_drained", model_q.size(), 0);
    chk("rand_in_eq_out", n_out, n_in);
    chk("rand_traffic_seen", int'(n_in > 1000), 1);

    // Forward-only slice: capacity, same-cycle ready chain, toggling d_ready
    sel(2, 1, 4);
    for (int c = 0; c < 8; c++) step(1'b1, 32'h400 + 32'(c), 1'b0, 1'b0);
    chk("m1_capacity", n_in, 4);
    chk("m1_full_u_ready", int'(s_ur), 0);
    for (int c = 0; c < 200; c++) step(1'b1, $urandom, 1'(c % 2 == 0), 1'b0);
    for (int c = 0; c < 20 && model_q.size() > 0; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("m1_drained", model_q.size(), 0);
    chk("m1_in_eq_out", n_out, n_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
